// File: rtl/axi4_mgr_sched_pkg.sv
// Shared state encoding and constants for the AXI4 manager command scheduler.
package axi4_mgr_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ISSUE = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam int REQ_WR = 0;
  localparam int REQ_RD = 1;

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [1:0] reqMask(input logic isRead);
    logic [1:0] mask;
    mask = 2'b00;
    if (isRead) mask[REQ_RD] = 1'b1;
    else        mask[REQ_WR] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after a rotating pointer
// and advances the pointer past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [N-1:0]  req_i,
  input  logic          enable_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   cand;
  logic          found;

  // One extra bit on the candidate keeps ptr+i from overflowing before the wrap.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && req_i[cand[IW-1:0]]) begin
        found = 1'b1;
        idx_o = cand[IW-1:0];
      end
    end
    if (found && enable_i) gnt_o[idx_o] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found && enable_i) ptr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/axi4_mgr_cmd_sched.sv
// Command scheduler sharing the AXI4 manager wrapper's single req/rsp port between
// NUM_REQ requesters, with FIFO-occupancy gating and a hung-manager timeout.
module axi4_mgr_cmd_sched
  import axi4_mgr_sched_pkg::*;
#(
  parameter  int NUM_REQ          = 4,
  parameter  int AXI_ADDR_WIDTH   = 32,
  parameter  int DATA_COUNT_WIDTH = 8,
  parameter  int FIFO_DEPTH       = 256,
  parameter  int TIMEOUT_CYCLES   = 4096,
  localparam int IW               = $clog2(NUM_REQ)
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic [NUM_REQ-1:0]                   cmd_valid_i,
  output logic [NUM_REQ-1:0]                   cmd_ready_o,
  input  logic [NUM_REQ-1:0]                   cmd_rd_i,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]    cmd_addr_i,
  input  logic [NUM_REQ*DATA_COUNT_WIDTH-1:0]  cmd_count_i,
  output logic                                 done_valid_o,
  output logic [IW-1:0]                        done_id_o,
  output logic [1:0]                           done_err_o,
  output logic                                 fault_o,
  output logic [1:0]                           mgr_req_o,
  output logic [AXI_ADDR_WIDTH-1:0]            mgr_wr_addr_o,
  output logic [AXI_ADDR_WIDTH-1:0]            mgr_rd_addr_o,
  output logic [DATA_COUNT_WIDTH-1:0]          mgr_rd_count_o,
  input  logic [1:0]                           mgr_rsp_i,
  input  logic [1:0]                           mgr_wr_err_i,
  input  logic [1:0]                           mgr_rd_err_i,
  input  logic [DATA_COUNT_WIDTH-1:0]          wr_fifo_usage_i,
  input  logic                                 wr_fifo_full_i,
  input  logic [DATA_COUNT_WIDTH-1:0]          rd_fifo_usage_i,
  input  logic                                 rd_fifo_full_i
);

  localparam int             TW        = $clog2(TIMEOUT_CYCLES);
  localparam int             CW        = DATA_COUNT_WIDTH + 1;
  localparam logic [CW-1:0]  DEPTH_EXT = CW'(FIFO_DEPTH);

  state_t                        state_q, state_d;
  logic                          rd_q, rd_d;
  logic [AXI_ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_COUNT_WIDTH-1:0]   count_q, count_d;
  logic [IW-1:0]                 id_q, id_d;
  logic [1:0]                    err_q, err_d;
  logic [TW-1:0]                 timer_q, timer_d;

  logic [NUM_REQ-1:0]            gnt;
  logic [IW-1:0]                 gntIdx;
  logic                          arbEnable;
  logic [AXI_ADDR_WIDTH-1:0]     newAddr;
  logic [DATA_COUNT_WIDTH-1:0]   newCount;
  logic [CW-1:0]                 wrAvail, rdFree, countExt;
  logic                          fifoOk, rspHit;

  assign arbEnable = rstn_i && (state_q == IDLE);

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .req_i    (cmd_valid_i),
    .enable_i (arbEnable),
    .gnt_o    (gnt),
    .idx_o    (gntIdx)
  );

  assign newAddr  = cmd_addr_i[gntIdx*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
  assign newCount = cmd_count_i[gntIdx*DATA_COUNT_WIDTH +: DATA_COUNT_WIDTH];

  // Usage reads as 0 when a FIFO is exactly full, so the full flags override it.
  assign wrAvail  = wr_fifo_full_i ? DEPTH_EXT : {1'b0, wr_fifo_usage_i};
  assign rdFree   = rd_fifo_full_i ? '0 : DEPTH_EXT - {1'b0, rd_fifo_usage_i};
  assign countExt = {1'b0, count_q};
  assign fifoOk   = rd_q ? (rdFree >= countExt) : (wrAvail >= countExt);
  assign rspHit   = rd_q ? mgr_rsp_i[REQ_RD] : mgr_rsp_i[REQ_WR];

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    count_d = count_q;
    id_d    = id_q;
    err_d   = err_q;
    timer_d = timer_q;

    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          rd_d    = cmd_rd_i[gntIdx];
          addr_d  = newAddr;
          count_d = newCount;
          id_d    = gntIdx;
          timer_d = '0;
          if (newCount == '0) begin
            err_d   = RESP_SLVERR;
            state_d = DONE;
          end else begin
            err_d   = 2'b00;
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (fifoOk) state_d = ISSUE;
      end
      // A response on the final timeout cycle still completes normally.
      ISSUE: begin
        if (rspHit) begin
          err_d   = rd_q ? mgr_rd_err_i : mgr_wr_err_i;
          state_d = DONE;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o    = gnt;
    mgr_req_o      = 2'b00;
    mgr_wr_addr_o  = '0;
    mgr_rd_addr_o  = '0;
    mgr_rd_count_o = '0;
    done_valid_o   = 1'b0;
    done_id_o      = '0;
    done_err_o     = 2'b00;
    fault_o        = 1'b0;

    if (state_q == ISSUE) begin
      mgr_req_o = reqMask(rd_q);
      if (rd_q) begin
        mgr_rd_addr_o  = addr_q;
        mgr_rd_count_o = count_q;
      end else begin
        mgr_wr_addr_o  = addr_q;
      end
    end
    if (state_q == DONE) begin
      done_valid_o = 1'b1;
      done_id_o    = id_q;
      done_err_o   = err_q;
    end
    if (state_q == FAULT) fault_o = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      count_q <= '0;
      id_q    <= '0;
      err_q   <= 2'b00;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      id_q    <= id_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

endmodule

// File: tb/tb_axi4_mgr_cmd_sched.sv
// Self-checking bench for axi4_mgr_cmd_sched: directed and randomized commands
// checked against a transaction-level round-robin / FIFO-gating model.
module tb_axi4_mgr_cmd_sched;
  import axi4_mgr_sched_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int AW      = 32;
  localparam int DW      = 8;
  localparam int DEPTH   = 256;
  localparam int TMO     = 4096;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NUM_REQ-1:0]   cmdValid, cmdReady, cmdRd;
  logic [NUM_REQ*AW-1:0] cmdAddr;
  logic [NUM_REQ*DW-1:0] cmdCount;
  logic                 doneValid;
  logic [1:0]           doneId, doneErr;
  logic                 fault;
  logic [1:0]           mgrReq, mgrRsp, wrErr, rdErr;
  logic [AW-1:0]        wrAddr, rdAddr;
  logic [DW-1:0]        rdCount, wrUse, rdUse;
  logic                 wrFull, rdFull;

  int checks = 0;
  int errors = 0;
  int modelPtr = 0;

  logic [NUM_REQ-1:0]   reqRd;
  logic [AW-1:0]        reqAddr [NUM_REQ];
  int                   reqCount [NUM_REQ];

  always #5 clk = ~clk;

  axi4_mgr_cmd_sched #(
    .NUM_REQ          (NUM_REQ),
    .AXI_ADDR_WIDTH   (AW),
    .DATA_COUNT_WIDTH (DW),
    .FIFO_DEPTH       (DEPTH),
    .TIMEOUT_CYCLES   (TMO)
  ) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .cmd_valid_i     (cmdValid),
    .cmd_ready_o     (cmdReady),
    .cmd_rd_i        (cmdRd),
    .cmd_addr_i      (cmdAddr),
    .cmd_count_i     (cmdCount),
    .done_valid_o    (doneValid),
    .done_id_o       (doneId),
    .done_err_o      (doneErr),
    .fault_o         (fault),
    .mgr_req_o       (mgrReq),
    .mgr_wr_addr_o   (wrAddr),
    .mgr_rd_addr_o   (rdAddr),
    .mgr_rd_count_o  (rdCount),
    .mgr_rsp_i       (mgrRsp),
    .mgr_wr_err_i    (wrErr),
    .mgr_rd_err_i    (rdErr),
    .wr_fifo_usage_i (wrUse),
    .wr_fifo_full_i  (wrFull),
    .rd_fifo_usage_i (rdUse),
    .rd_fifo_full_i  (rdFull)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference round-robin: first valid requester at or after the pointer, wrapping.
  function automatic int modelPick(input logic [NUM_REQ-1:0] mask, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (mask[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic bit modelGate(input logic rd, input int count);
    int effUse;
    int effFree;
    effUse  = wrFull ? DEPTH : int'(wrUse);
    effFree = rdFull ? 0 : DEPTH - int'(rdUse);
    return rd ? (effFree >= count) : (effUse >= count);
  endfunction

  task automatic applyStimulus(input logic [NUM_REQ-1:0] mask);
    for (int i = 0; i < NUM_REQ; i++) begin
      cmdRd[i]                = reqRd[i];
      cmdAddr[i*AW +: AW]     = reqAddr[i];
      cmdCount[i*DW +: DW]    = DW'(reqCount[i]);
    end
    cmdValid = mask;
  endtask

  task automatic doReset(input int cycles);
    rstn     = 1'b0;
    cmdValid = '0;
    mgrRsp   = 2'b00;
    repeat (cycles) @(negedge clk);
    #1;
    checkOutput("rst_ready",      64'(cmdReady),  64'(0));
    checkOutput("rst_done_valid", 64'(doneValid), 64'(0));
    checkOutput("rst_done_id",    64'(doneId),    64'(0));
    checkOutput("rst_done_err",   64'(doneErr),   64'(0));
    checkOutput("rst_fault",      64'(fault),     64'(0));
    checkOutput("rst_req",        64'(mgrReq),    64'(0));
    checkOutput("rst_wr_addr",    64'(wrAddr),    64'(0));
    checkOutput("rst_rd_addr",    64'(rdAddr),    64'(0));
    checkOutput("rst_rd_count",   64'(rdCount),   64'(0));
    rstn     = 1'b1;
    modelPtr = 0;
  endtask

  // Entered and left at negedge+#1 with the DUT idle.
  // rspDelay >= 0: cycles before the response; -1: never respond; -2: reset mid-ISSUE.
  task automatic runTxn(input logic [NUM_REQ-1:0] mask, input int rspDelay, input logic [1:0] errVal);
    int         g;
    logic       rd;
    int         cnt;
    logic [1:0] expReq;
    applyStimulus(mask);
    #1;
    g = modelPick(mask, modelPtr);
    checkOutput("accept_ready", 64'(cmdReady), 64'(1) << g);
    modelPtr = (g + 1) % NUM_REQ;
    rd  = reqRd[g];
    cnt = reqCount[g];
    expReq = rd ? 2'b10 : 2'b01;
    @(negedge clk); #1;
    checkOutput("busy_ready", 64'(cmdReady), 64'(0));
    if (cnt == 0) begin
      checkOutput("zero_done_valid", 64'(doneValid), 64'(1));
      checkOutput("zero_done_id",    64'(doneId),    64'(g));
      checkOutput("zero_done_err",   64'(doneErr),   64'(RESP_SLVERR));
      checkOutput("zero_req",        64'(mgrReq),    64'(0));
      @(negedge clk); #1;
      checkOutput("zero_idle_done", 64'(doneValid), 64'(0));
      checkOutput("zero_idle_req",  64'(mgrReq),    64'(0));
      return;
    end
    checkOutput("check_req", 64'(mgrReq), 64'(0));
    if (!modelGate(rd, cnt)) begin
      mgrRsp = 2'b11;
      repeat (3) begin
        @(negedge clk); #1;
        checkOutput("gate_hold_req",  64'(mgrReq),    64'(0));
        checkOutput("gate_hold_done", 64'(doneValid), 64'(0));
      end
      mgrRsp = 2'b00;
      if (rd) begin rdFull = 1'b0; rdUse = DW'(DEPTH - cnt); end
      else    begin wrFull = 1'b0; wrUse = DW'(cnt); end
    end
    @(negedge clk); #1;
    checkOutput("issue_req",      64'(mgrReq),  64'(expReq));
    checkOutput("issue_wr_addr",  64'(wrAddr),  rd ? 64'(0) : 64'(reqAddr[g]));
    checkOutput("issue_rd_addr",  64'(rdAddr),  rd ? 64'(reqAddr[g]) : 64'(0));
    checkOutput("issue_rd_count", 64'(rdCount), rd ? 64'(cnt) : 64'(0));
    if (rspDelay == -1) begin
      mgrRsp = rd ? 2'b01 : 2'b10;
      repeat (TMO - 1) @(negedge clk);
      #1;
      checkOutput("timeout_last_req", 64'(mgrReq), 64'(expReq));
      @(negedge clk); #1;
      checkOutput("timeout_req_drop", 64'(mgrReq), 64'(0));
      checkOutput("timeout_fault",    64'(fault),  64'(1));
      mgrRsp = expReq;
      repeat (3) begin
        @(negedge clk); #1;
        checkOutput("fault_ready",   64'(cmdReady),  64'(0));
        checkOutput("fault_no_done", 64'(doneValid), 64'(0));
        checkOutput("fault_sticky",  64'(fault),     64'(1));
      end
      mgrRsp = 2'b00;
      return;
    end
    if (rspDelay == -2) begin
      repeat (2) @(negedge clk);
      #1;
      checkOutput("abort_req_before", 64'(mgrReq), 64'(expReq));
      doReset(1);
      mgrRsp = expReq;
      repeat (3) begin
        @(negedge clk); #1;
        checkOutput("abort_no_done", 64'(doneValid), 64'(0));
        checkOutput("abort_req",     64'(mgrReq),    64'(0));
      end
      mgrRsp = 2'b00;
      return;
    end
    for (int d = 0; d < rspDelay; d++) begin
      mgrRsp = rd ? {1'b0, 1'($urandom)} : {1'($urandom), 1'b0};
      @(negedge clk); #1;
      checkOutput("issue_hold_req",  64'(mgrReq),             64'(expReq));
      checkOutput("issue_hold_addr", rd ? 64'(rdAddr) : 64'(wrAddr), 64'(reqAddr[g]));
      checkOutput("issue_hold_done", 64'(doneValid),          64'(0));
    end
    mgrRsp = expReq | (rd ? {1'b0, 1'($urandom)} : {1'($urandom), 1'b0});
    if (rd) begin rdErr = errVal; wrErr = ~errVal; end
    else    begin wrErr = errVal; rdErr = ~errVal; end
    @(negedge clk); #1;
    mgrRsp = 2'b00;
    wrErr  = 2'($urandom);
    rdErr  = 2'($urandom);
    #1;
    checkOutput("done_valid",   64'(doneValid), 64'(1));
    checkOutput("done_id",      64'(doneId),    64'(g));
    checkOutput("done_err",     64'(doneErr),   64'(errVal));
    checkOutput("done_req",     64'(mgrReq),    64'(0));
    checkOutput("done_wr_addr", 64'(wrAddr),    64'(0));
    checkOutput("done_rd_addr", 64'(rdAddr),    64'(0));
    checkOutput("done_fault",   64'(fault),     64'(0));
    @(negedge clk); #1;
    checkOutput("idle_done_clear", 64'(doneValid), 64'(0));
  endtask

  initial begin
    rstn = 1'b0; cmdValid = '0; cmdRd = '0; cmdAddr = '0; cmdCount = '0;
    mgrRsp = 2'b00; wrErr = 2'b00; rdErr = 2'b00;
    wrUse = '0; wrFull = 1'b0; rdUse = '0; rdFull = 1'b0;
    reqRd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin reqAddr[i] = '0; reqCount[i] = 1; end

    doReset(2);

    // Plain write, FIFO holds exactly the needed beats; req held 7 cycles.
    reqRd[0] = 1'b0; reqAddr[0] = 32'h0000_1000; reqCount[0] = 4; wrUse = 8'd4;
    runTxn(4'b0001, 6, 2'b00);

    // Read blocked by 6 free entries until usage drops to 240.
    reqRd[1] = 1'b1; reqAddr[1] = 32'h0000_2000; reqCount[1] = 16; rdUse = 8'd250;
    runTxn(4'b0010, 3, 2'b00);

    // Full write FIFO with usage 0 counts as 256 entries.
    reqRd[2] = 1'b0; reqAddr[2] = 32'h0000_3000; reqCount[2] = 255; wrUse = 8'd0; wrFull = 1'b1;
    runTxn(4'b0100, 2, 2'b01);

    // Full read FIFO leaves no room even for one beat.
    reqRd[3] = 1'b1; reqAddr[3] = 32'h0000_4000; reqCount[3] = 1; rdUse = 8'd0; rdFull = 1'b1;
    runTxn(4'b1000, 1, 2'b11);

    // Zero-length command completes with SLVERR without touching the manager.
    reqRd[0] = 1'b0; reqCount[0] = 0;
    runTxn(4'b0001, 0, 2'b00);

    // All requesters continuously valid.
    wrFull = 1'b1; rdFull = 1'b0; rdUse = 8'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      reqRd[i] = (i % 2 == 1); reqAddr[i] = 32'h0001_0000 + 32'(i * 16); reqCount[i] = 8;
    end
    for (int n = 0; n < 6; n++) runTxn(4'b1111, n % 3, 2'(n));

    for (int it = 0; it < 24; it++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        reqRd[r]    = 1'($urandom);
        reqAddr[r]  = $urandom;
        reqCount[r] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 255));
      end
      wrUse  = DW'($urandom_range(0, 255));
      wrFull = ($urandom_range(0, 3) == 0);
      rdUse  = DW'($urandom_range(0, 255));
      rdFull = ($urandom_range(0, 3) == 0);
      runTxn(NUM_REQ'($urandom_range(1, 15)), int'($urandom_range(0, 5)), 2'($urandom));
    end

    // Response on the very last allowed ISSUE cycle wins over the timeout.
    reqRd[0] = 1'b0; reqAddr[0] = 32'h0000_5000; reqCount[0] = 3; wrFull = 1'b1;
    runTxn(4'b0001, TMO - 1, 2'b00);
    checkOutput("rsp_on_timeout_no_fault", 64'(fault), 64'(0));

    reqRd[1] = 1'b1; reqAddr[1] = 32'h0000_6000; reqCount[1] = 2; rdUse = 8'd0; rdFull = 1'b0;
    runTxn(4'b0010, -2, 2'b00);

    reqRd[0] = 1'b0; reqAddr[0] = 32'h0000_7000; reqCount[0] = 5;
    runTxn(4'b0001, -1, 2'b00);

    doReset(1);

    reqRd[1] = 1'b1; reqAddr[1] = 32'h0000_8000; reqCount[1] = 7;
    runTxn(4'b0010, 1, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
